// File: rtl/snail_byte_scanner_pkg.sv
// rtl/snail_byte_scanner_pkg.sv - shared types and sizing helper for the snail byte scanner
package snail_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } det_state_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    REPORT = 2'b10
  } scan_state_e;

  // Smallest count width that can hold the most "01" hits a word can produce.
  function automatic int min_cnt_w(input int data_w);
    return $clog2((data_w + 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/snail_byte_scanner_if.sv
// rtl/snail_byte_scanner_if.sv - word input and result output handshakes of the scanner
interface snail_byte_scanner_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              in_valid_in;
  logic              in_ready_out;
  logic [DATA_W-1:0] in_data_in;
  logic              out_valid_out;
  logic              out_ready_in;
  logic [CNT_W-1:0]  out_count_out;
  logic              out_last_smile_out;

  modport master (
    output in_valid_in, in_data_in, out_ready_in,
    input  in_ready_out, out_valid_out, out_count_out, out_last_smile_out
  );

  modport slave (
    input  in_valid_in, in_data_in, out_ready_in,
    output in_ready_out, out_valid_out, out_count_out, out_last_smile_out
  );
endinterface

// File: rtl/snail_detect_core.sv
// rtl/snail_detect_core.sv - three-state Moore "01" detector with enable and sync clear
module snail_detect_core
  import snail_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic en_in,
  input  logic clear_in,
  input  logic bit_in,
  output logic smile_out,
  output logic hit_out
);

  det_state_e state_q, state_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S0;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_in) begin
      state_d = S0;
    end else if (en_in) begin
      // S0 and S2 react identically; only S1 remembers a pending "0".
      case (state_q)
        S1:      state_d = bit_in ? S2 : S1;
        default: state_d = bit_in ? S0 : S1;
      endcase
    end
  end

  assign smile_out = (state_q == S2);
  assign hit_out   = en_in & bit_in & (state_q == S1);

endmodule

// File: rtl/snail_byte_scanner.sv
// rtl/snail_byte_scanner.sv - serialises words into the "01" detector and reports hits per word
// Optional running total on total_count_out when SNAIL_SCAN_STATS_EN is defined.
module snail_byte_scanner
  import snail_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 clear_in,
  output logic                 busy_out,
`ifdef SNAIL_SCAN_STATS_EN
  output logic [15:0]          total_count_out,
`endif
  snail_byte_scanner_if.slave  bus
);

  localparam int BC_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  if (DATA_W < 2) begin : g_bad_data_w
    $error("snail_byte_scanner: DATA_W must be at least 2");
  end
  if (CNT_W < min_cnt_w(DATA_W)) begin : g_bad_cnt_w
    $error("snail_byte_scanner: CNT_W too small for DATA_W");
  end

  scan_state_e       state_q, state_d;
  logic [DATA_W-1:0] sreg_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic              accept;
  logic              det_en;
  logic              det_clear;
  logic              det_bit;
  logic              det_smile;
  logic              det_hit;

  assign accept    = (state_q == IDLE) & bus.in_valid_in;
  assign det_en    = (state_q == SHIFT);
  assign det_clear = (state_q == IDLE) & clear_in;
  assign det_bit   = MSB_FIRST ? sreg_q[DATA_W-1] : sreg_q[0];

  snail_detect_core u_core (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .en_in     (det_en),
    .clear_in  (det_clear),
    .bit_in    (det_bit),
    .smile_out (det_smile),
    .hit_out   (det_hit)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == BC_W'(DATA_W - 1)) state_d = REPORT;
      REPORT:  if (bus.out_ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      hit_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        sreg_q    <= bus.in_data_in;
        bit_cnt_q <= '0;
        hit_cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        sreg_q    <= MSB_FIRST ? {sreg_q[DATA_W-2:0], 1'b0} : {1'b0, sreg_q[DATA_W-1:1]};
        bit_cnt_q <= bit_cnt_q + BC_W'(1);
        if (det_hit) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready_out       = (state_q == IDLE);
  assign bus.out_valid_out      = (state_q == REPORT);
  assign bus.out_count_out      = hit_cnt_q;
  assign bus.out_last_smile_out = (state_q == REPORT) & det_smile;
  assign busy_out               = (state_q != IDLE);

`ifdef SNAIL_SCAN_STATS_EN
  logic [15:0] total_q;
  logic [16:0] total_sum;

  assign total_sum = {1'b0, total_q} + 17'(hit_cnt_q);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      total_q <= '0;
    end else if ((state_q == REPORT) && bus.out_ready_in) begin
      total_q <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
  end

  assign total_count_out = total_q;
`endif

endmodule

// File: tb/tb_snail_byte_scanner.sv
// tb/tb_snail_byte_scanner.sv - directed scoreboard bench for snail_byte_scanner
module tb_snail_byte_scanner;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic             smile;
  } exp_t;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  logic clear_in = 1'b0;
  logic busy_out;
`ifdef SNAIL_SCAN_STATS_EN
  logic [15:0] total_count_out;
  int          model_total = 0;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic prev_zero = 1'b0;

  snail_byte_scanner_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  snail_byte_scanner #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MSB_FIRST(1'b1)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .clear_in        (clear_in),
    .busy_out        (busy_out),
`ifdef SNAIL_SCAN_STATS_EN
    .total_count_out (total_count_out),
`endif
    .bus             (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Reference: a hit is any "1" directly after a "0" in the continuous bit stream.
  task automatic model_word(input logic [DATA_W-1:0] data, input logic clr);
    exp_t e;
    logic [DATA_W-1:0] d;
    logic b, hit;
    d = data;
    if (clr) prev_zero = 1'b0;
    e.cnt   = '0;
    e.smile = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      b   = d[i];
      hit = prev_zero & b;
      if (hit) e.cnt = e.cnt + 1'b1;
      e.smile   = hit;
      prev_zero = ~b;
    end
    exp_q.push_back(e);
  endtask

  task automatic accept_word(input string tag, input logic [DATA_W-1:0] data, input logic clr);
    int n;
    n = 0;
    while (!bus.in_ready_out && n < 40) begin step(); n++; end
    check({tag, "_ready"}, bus.in_ready_out, 1'b1);
    bus.in_valid_in = 1'b1;
    bus.in_data_in  = data;
    clear_in        = clr;
    step();
    bus.in_valid_in = 1'b0;
    clear_in        = 1'b0;
    check({tag, "_busy"}, busy_out, 1'b1);
  endtask

  task automatic wait_report(input string tag);
    exp_t e;
    int n;
    n = 0;
    while (!bus.out_valid_out && n < 40) begin step(); n++; end
    check({tag, "_latency"}, n, DATA_W);
    if (exp_q.size() == 0) begin
      check({tag, "_scoreboard_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_count"}, bus.out_count_out, e.cnt);
      check({tag, "_smile"}, bus.out_last_smile_out, e.smile);
`ifdef SNAIL_SCAN_STATS_EN
      model_total = model_total + int'(e.cnt);
      if (model_total > 16'hFFFF) model_total = 16'hFFFF;
`endif
    end
  endtask

  task automatic take_result(input string tag);
    bus.out_ready_in = 1'b1;
    step();
    bus.out_ready_in = 1'b0;
    check({tag, "_valid_drop"}, bus.out_valid_out, 1'b0);
    check({tag, "_idle_ready"}, bus.in_ready_out, 1'b1);
`ifdef SNAIL_SCAN_STATS_EN
    check({tag, "_total"}, total_count_out, model_total[15:0]);
`endif
  endtask

  task automatic run_word(input string tag, input logic [DATA_W-1:0] data, input logic clr);
    model_word(data, clr);
    accept_word(tag, data, clr);
    wait_report(tag);
    take_result(tag);
  endtask

  initial begin
    logic [CNT_W-1:0] held_cnt;
    bus.in_valid_in  = 1'b0;
    bus.in_data_in   = '0;
    bus.out_ready_in = 1'b0;

    #2;
    check("rst_in_ready", bus.in_ready_out, 1'b1);
    check("rst_out_valid", bus.out_valid_out, 1'b0);
    check("rst_count", bus.out_count_out, '0);
    check("rst_smile", bus.out_last_smile_out, 1'b0);
    check("rst_busy", busy_out, 1'b0);
    step();
    rst_n_in = 1'b1;
    step();

    run_word("w55", 8'h55, 1'b0);
    run_word("wFF", 8'hFF, 1'b0);
    run_word("w00", 8'h00, 1'b0);
    run_word("w00b", 8'h00, 1'b0);
    run_word("w80_cross", 8'h80, 1'b0);
    run_word("w00c", 8'h00, 1'b0);
    run_word("w80_clear", 8'h80, 1'b1);

    // Hold the result while a new word is offered; it must not be taken.
    model_word(8'h35, 1'b0);
    accept_word("hold", 8'h35, 1'b0);
    wait_report("hold");
    held_cnt = bus.out_count_out;
    bus.in_valid_in = 1'b1;
    bus.in_data_in  = 8'hF0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", bus.out_valid_out, 1'b1);
      check("hold_count", bus.out_count_out, held_cnt);
      check("hold_in_ready", bus.in_ready_out, 1'b0);
    end
    bus.in_valid_in = 1'b0;
    take_result("hold");
    step();
    check("hold_not_taken", busy_out, 1'b0);

    // Asynchronous reset in the middle of a word.
    accept_word("mid", 8'h55, 1'b0);
    step();
    step();
    step();
    #2;
    rst_n_in = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid_out, 1'b0);
    check("mid_rst_busy", busy_out, 1'b0);
    check("mid_rst_ready", bus.in_ready_out, 1'b1);
    prev_zero = 1'b0;
`ifdef SNAIL_SCAN_STATS_EN
    model_total = 0;
    check("mid_rst_total", total_count_out, 16'h0000);
`endif
    step();
    rst_n_in = 1'b1;
    step();
    run_word("wAA", 8'hAA, 1'b0);

`ifdef SNAIL_SCAN_STATS_EN
    run_word("st55a", 8'h55, 1'b0);
    run_word("st55b", 8'h55, 1'b0);
    force dut.total_q = 16'hFFFE;
    step();
    release dut.total_q;
    model_total = 16'hFFFE;
    run_word("sat55", 8'h55, 1'b0);
    check("sat_hold", total_count_out, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/snail_byte_scanner.md
Name: snail_byte_scanner

Overview:
- Word-level controller that sequences the "01" Moore pattern detector (snail core).
- Accepts DATA_W-bit words over a valid/ready handshake and serialises them into the detector, one bit per clock.
- Counts detector hits per word and returns the count over a second valid/ready handshake.
- Detector history carries across words, so a "0" ending one word followed by a "1" starting the next counts as a hit.

Parameters:
- DATA_W, 8, input word width in bits (>= 2)
- CNT_W, 4, hit-count width; must satisfy CNT_W >= clog2(ceil(DATA_W/2)+1)
- MSB_FIRST, 1, 1 = shift bit DATA_W-1 first; 0 = bit 0 first

Ports:
- clk_in  input  1  clock, rising edge
- rst_n_in  input  1  reset, asynchronous assert, active-low
- clear_in  input  1  synchronous detector-history clear, honoured in IDLE only
- in_valid_in  input  1  input word valid
- in_ready_out  output  1  scanner can accept a word
- in_data_in  input  DATA_W  input word
- out_valid_out  output  1  result valid
- out_ready_in  input  1  consumer accepts result
- out_count_out  output  CNT_W  hit count for the word
- out_last_smile_out  output  1  detector smile after the word's final bit (word ends "01")
- busy_out  output  1  high in SHIFT or REPORT

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - Scanner FSM goes to IDLE; detector goes to S0.
  - Shift register, bit counter, hit count and last_smile all clear to 0.
  - Outputs: in_ready_out=1, out_valid_out=0, out_count_out=0, out_last_smile_out=0, busy_out=0.
  - Any in-flight word is discarded.
- Detector semantics (S0/S1/S2, Moore):
  - S0: 0->S1, 1->S0.
  - S1: 0->S1, 1->S2.
  - S2: 0->S1, 1->S0.
  - smile = (state==S2).
  - A hit is counted on the shift cycle where the detector is in S1 and the shifted bit is 1.
- Scanner FSM:
  - IDLE:
    - in_ready_out=1.
    - If clear_in=1, the detector loads S0 this cycle.
    - On in_valid_in & in_ready_out: load the shift register, zero bit_cnt and hit_cnt, go to SHIFT.
    - clear_in and an accept in the same cycle: the clear applies, and the new word's first bit sees S0.
  - SHIFT:
    - in_ready_out=0.
    - Each cycle, present the next bit (per MSB_FIRST) to the detector with enable high.
    - Increment hit_cnt on a hit and increment bit_cnt.
    - After exactly DATA_W cycles, go to REPORT.
    - clear_in is ignored.
  - REPORT:
    - out_valid_out=1; out_count_out=hit_cnt; out_last_smile_out=detector smile.
    - Outputs are held stable while out_ready_in=0.
    - On out_ready_in: go to IDLE.
    - The detector is not enabled and keeps its state.
- Latency:
  - Accept at edge T; SHIFT covers edges T+1 .. T+DATA_W.
  - out_valid_out rises after edge T+DATA_W.
  - Minimum throughput: one word per DATA_W+2 cycles.
- Arithmetic:
  - hit_cnt is an unsigned CNT_W-bit value.
  - It cannot overflow given the parameter constraint; no saturation logic is needed.
- Back-pressure: in_ready_out stays low in SHIFT and REPORT, so input words are never dropped.
- Assertion errors: CNT_W below the minimum, or DATA_W < 2, is flagged at elaboration.

Optional Feature:
- Macro: SNAIL_SCAN_STATS_EN
- Defined:
  - Adds output total_count_out [15:0]: a saturating running sum of out_count_out.
  - It is added on each REPORT handshake and holds at 16'hFFFF once saturated.
  - Cleared only by reset; clear_in does not affect it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package snail_pkg:
  - Detector state encoding S0=2'b00, S1=2'b01, S2=2'b10.
  - Scanner FSM enum IDLE/SHIFT/REPORT.
  - Function for the minimum CNT_W.
- Sub-module snail_detect_core:
  - 3-state Moore detector with enable and sync clear inputs.
  - Outputs smile and a combinational hit pulse (state==S1 & bit & enable).

Test Plan:
1. Reset, MSB_FIRST=1, send 8'h55 -> out_valid_out after 8 SHIFT cycles; out_count_out=4, out_last_smile_out=1.
2. Send 8'hFF, then 8'h00 -> counts 0 and 0; out_last_smile_out=0 for both.
3. Send 8'h00, then 8'h80 -> second count=1 (cross-word hit). Repeat with clear_in=1 in the cycle 8'h80 is accepted -> count=0.
4. Hold out_ready_in low 5 cycles in REPORT -> out_valid_out held at 1, count stable, in_ready_out=0, an offered word is not accepted; release -> IDLE next cycle, in_ready_out=1.
5. Assert rst_n_in low mid-SHIFT (bit 3 of 8'h55) -> asynchronously out_valid_out=0, busy_out=0, in_ready_out=1. After release, 8'hAA gives count=3.
6. With SNAIL_SCAN_STATS_EN defined, send 8'h55, 8'h55, 8'hAA -> counts 4, 4, 3; total_count_out=11. Force the counter near saturation -> it holds at 16'hFFFF.
